// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch front end for the LEGv8 datapath.
// Fetches the instruction at CurrentPC, holds it for decode, and loads NextPC on retire.
module pc_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 64,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         CNT_WIDTH   = 32
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [PC_WIDTH-1:0]    NextPC,
  input  logic                   Advance,
  input  logic                   Stall,
  output logic                   IMemReq,
  output logic [PC_WIDTH-1:0]    IMemAddr,
  input  logic                   IMemReady,
  input  logic [INSTR_WIDTH-1:0] IMemData,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   InstrValid,
  output logic                   Misaligned,
  output logic [CNT_WIDTH-1:0]   RetireCount
);

  typedef enum logic [1:0] {
    RST,
    FETCH,
    HOLD,
    FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   mis_q, mis_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   retire;

  assign retire = Advance & ~Stall;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= RST;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  // The PC is only ever loaded from NextPC; address stays frozen while a fetch is pending.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        if (IMemReady) begin
          instr_d = IMemData;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          pc_d    = NextPC;
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          if (NextPC[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = FAULT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = RST;
    endcase
  end

  always_comb begin
    IMemReq     = (state_q == FETCH);
    IMemAddr    = pc_q;
    CurrentPC   = pc_q;
    Instruction = instr_q;
    InstrValid  = valid_q;
    Misaligned  = mis_q;
    RetireCount = cnt_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vectors with literal checks,
// plus a behavioural model compared against the DUT on every cycle.
module tb_pc_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic [63:0] NextPC;
  logic        Advance;
  logic        Stall;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [63:0] CurrentPC;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Misaligned;
  logic [31:0] RetireCount;

  int checks = 0;
  int fails  = 0;

  // Model state: what the block must present, described in terms of behaviour.
  logic        mKnown = 1'b0;
  logic        mStarted;
  logic        mHolding;
  logic        mFault;
  logic [63:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mCount;

  pc_fetch_unit dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .NextPC     (NextPC),
    .Advance    (Advance),
    .Stall      (Stall),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemData   (IMemData),
    .CurrentPC  (CurrentPC),
    .Instruction(Instruction),
    .InstrValid (InstrValid),
    .Misaligned (Misaligned),
    .RetireCount(RetireCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic applyStimulus(input logic rst, input logic adv, input logic stl,
                               input logic rdy, input logic [31:0] data, input logic [63:0] npc);
    Reset     = rst;
    Advance   = adv;
    Stall     = stl;
    IMemReady = rdy;
    IMemData  = data;
    NextPC    = npc;
    @(negedge CLK);
  endtask

  always @(posedge CLK) begin
    if (Reset) begin
      mKnown   <= 1'b1;
      mStarted <= 1'b0;
      mHolding <= 1'b0;
      mFault   <= 1'b0;
      mPc      <= 64'h0;
      mInstr   <= 32'h0;
      mCount   <= 32'h0;
    end else if (!mStarted) begin
      mStarted <= 1'b1;
    end else if (!mFault) begin
      if (!mHolding) begin
        if (IMemReady) begin
          mInstr   <= IMemData;
          mHolding <= 1'b1;
        end
      end else if (Advance && !Stall) begin
        mPc      <= NextPC;
        mHolding <= 1'b0;
        mCount   <= mCount + 32'd1;
        if (NextPC[1:0] != 2'b00) mFault <= 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (mKnown) begin
      checkOutput("model.IMemReq", 64'(IMemReq), 64'(mStarted && !mHolding && !mFault));
      checkOutput("model.IMemAddr", IMemAddr, mPc);
      checkOutput("model.CurrentPC", CurrentPC, mPc);
      checkOutput("model.Instruction", 64'(Instruction), 64'(mInstr));
      checkOutput("model.InstrValid", 64'(InstrValid), 64'(mHolding));
      checkOutput("model.Misaligned", 64'(Misaligned), 64'(mFault));
      checkOutput("model.RetireCount", 64'(RetireCount), 64'(mCount));
    end
  end

  initial begin
    Reset = 1'b1; Advance = 1'b0; Stall = 1'b0; IMemReady = 1'b0;
    IMemData = 32'h0; NextPC = 64'h0;

    // Reset sequence and straight-line fetch
    applyStimulus(1, 0, 0, 1, 32'hAAAA0001, 64'h0);
    applyStimulus(1, 0, 0, 1, 32'hAAAA0001, 64'h0);
    checkOutput("rst.CurrentPC", CurrentPC, 64'h0);
    checkOutput("rst.IMemReq", 64'(IMemReq), 64'h0);
    checkOutput("rst.InstrValid", 64'(InstrValid), 64'h0);
    checkOutput("rst.RetireCount", 64'(RetireCount), 64'h0);
    applyStimulus(0, 0, 0, 1, 32'hAAAA0001, 64'h0);
    checkOutput("t1.IMemReq", 64'(IMemReq), 64'h1);
    checkOutput("t1.IMemAddr0", IMemAddr, 64'h0);
    applyStimulus(0, 0, 0, 1, 32'hAAAA0001, 64'h0);
    checkOutput("t1.InstrValid", 64'(InstrValid), 64'h1);
    checkOutput("t1.Instruction", 64'(Instruction), 64'hAAAA0001);
    applyStimulus(0, 1, 0, 0, 32'h0, 64'h4);
    checkOutput("t1.IMemAddr4", IMemAddr, 64'h4);
    checkOutput("t1.RetireCount", 64'(RetireCount), 64'h1);

    // Wait states at PC=4
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 32'hFFFF0000, 64'h40);
      checkOutput("t2.IMemReq", 64'(IMemReq), 64'h1);
      checkOutput("t2.IMemAddr", IMemAddr, 64'h4);
      checkOutput("t2.InstrValid", 64'(InstrValid), 64'h0);
    end
    applyStimulus(0, 0, 0, 1, 32'h12345678, 64'h0);
    checkOutput("t2.InstrValid", 64'(InstrValid), 64'h1);
    checkOutput("t2.Instruction", 64'(Instruction), 64'h12345678);
    checkOutput("t2.RetireCount", 64'(RetireCount), 64'h1);

    // Branch taken from PC=0 to PC=8
    applyStimulus(1, 0, 0, 0, 32'h0, 64'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 64'h0);
    applyStimulus(0, 0, 0, 1, 32'h8B000000, 64'h0);
    applyStimulus(0, 1, 0, 0, 32'h0, 64'h8);
    checkOutput("t3.IMemAddr", IMemAddr, 64'h8);
    checkOutput("t3.CurrentPC", CurrentPC, 64'h8);
    checkOutput("t3.Misaligned", 64'(Misaligned), 64'h0);

    // Stall in HOLD; memory ready outside FETCH must be ignored
    applyStimulus(0, 0, 0, 1, 32'h0000C0DE, 64'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 1, 32'hBADBAD00, 64'h10);
      checkOutput("t4.CurrentPC", CurrentPC, 64'h8);
      checkOutput("t4.RetireCount", 64'(RetireCount), 64'h1);
      checkOutput("t4.Instruction", 64'(Instruction), 64'h0000C0DE);
    end
    applyStimulus(0, 1, 0, 0, 32'h0, 64'hC);
    checkOutput("t4.RetireCount", 64'(RetireCount), 64'h2);
    checkOutput("t4.CurrentPC", CurrentPC, 64'hC);
    applyStimulus(0, 1, 0, 0, 32'h0, 64'h20);
    checkOutput("t4.AdvInFetch", 64'(RetireCount), 64'h2);

    // Misaligned fault
    applyStimulus(0, 0, 0, 1, 32'h11112222, 64'h0);
    applyStimulus(0, 1, 0, 0, 32'h0, 64'h6);
    checkOutput("t5.Misaligned", 64'(Misaligned), 64'h1);
    checkOutput("t5.CurrentPC", CurrentPC, 64'h6);
    checkOutput("t5.RetireCount", 64'(RetireCount), 64'h3);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 1, 32'h33334444, 64'h8);
      checkOutput("t5.IMemReq", 64'(IMemReq), 64'h0);
      checkOutput("t5.Held", CurrentPC, 64'h6);
    end
    applyStimulus(1, 0, 0, 0, 32'h0, 64'h0);
    checkOutput("t5.Cleared", 64'(Misaligned), 64'h0);
    checkOutput("t5.ResetPC", CurrentPC, 64'h0);

    // PC near the top of the address space, then back to zero
    applyStimulus(0, 0, 0, 0, 32'h0, 64'h0);
    applyStimulus(0, 0, 0, 1, 32'h55556666, 64'h0);
    applyStimulus(0, 1, 0, 0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap.TopPC", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(0, 0, 0, 1, 32'h77778888, 64'h0);
    applyStimulus(0, 1, 0, 0, 32'h0, 64'h0);
    checkOutput("wrap.ZeroPC", CurrentPC, 64'h0);
    checkOutput("wrap.Misaligned", 64'(Misaligned), 64'h0);
    checkOutput("wrap.RetireCount", 64'(RetireCount), 64'h2);

    // Reset in the same cycle as memory ready at PC=8
    applyStimulus(0, 0, 0, 1, 32'h9999AAAA, 64'h0);
    applyStimulus(0, 1, 0, 0, 32'h0, 64'h8);
    checkOutput("t6.PrePC", CurrentPC, 64'h8);
    applyStimulus(1, 0, 0, 1, 32'hDEADBEEF, 64'h0);
    checkOutput("t6.InstrValid", 64'(InstrValid), 64'h0);
    checkOutput("t6.Instruction", 64'(Instruction), 64'h0);
    checkOutput("t6.CurrentPC", CurrentPC, 64'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 64'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the architectural PC register and fetches the instruction at that address from instruction memory over a request/ready handshake.
- Consumes the NextPC value produced by the next-PC logic, loading it only when the current instruction retires.
- Presents the fetched instruction and its PC to decode, and flags misaligned PCs.
- Sits at the front of the single-cycle/multicycle LEGv8 datapath, upstream of decode and downstream of the next-PC logic.

Parameters:
- PC_WIDTH, 64, width of the PC and of the memory address.
- INSTR_WIDTH, 32, width of an instruction word.
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- NextPC  input  PC_WIDTH  next PC from the next-PC logic; sampled only on a retire.
- Advance  input  1  control asserts it when the current instruction completes.
- Stall  input  1  suppresses Advance while high.
- IMemReq  output  1  instruction memory request valid.
- IMemAddr  output  PC_WIDTH  instruction memory address; always equals CurrentPC.
- IMemReady  input  1  memory indicates IMemData is valid this cycle.
- IMemData  input  INSTR_WIDTH  instruction word returned by memory.
- CurrentPC  output  PC_WIDTH  architectural PC of the instruction being fetched or held.
- Instruction  output  INSTR_WIDTH  registered instruction word for decode.
- InstrValid  output  1  Instruction/CurrentPC pair is valid for decode.
- Misaligned  output  1  sticky fault: a loaded PC had bits [1:0] != 0.
- RetireCount  output  CNT_WIDTH  number of retired instructions.

Behaviour:
Reset:
- Clock and reset: one clock, CLK; reset is synchronous and active-high, named Reset. Reset has priority over every other input, including mid-handshake.
- Reset values: CurrentPC=RESET_PC, Instruction=0, InstrValid=0, Misaligned=0, RetireCount=0, IMemReq=0, state=RST.

States:
- RST: one cycle after Reset deasserts, go to FETCH. IMemReq=0.
- FETCH: IMemReq=1, IMemAddr=CurrentPC.
  - When IMemReady=1 in the same cycle: Instruction<=IMemData, InstrValid<=1, go to HOLD.
  - Otherwise remain in FETCH with the request held stable; the address must not change while a request is pending.
  - Advance is ignored in FETCH.
- HOLD: IMemReq=0, InstrValid=1, Instruction stable. Retire occurs when Advance=1 and Stall=0:
  - CurrentPC<=NextPC.
  - InstrValid<=0.
  - RetireCount<=RetireCount+1.
  - If NextPC[1:0]!=0, go to FAULT; otherwise go to FETCH.
  - Advance with Stall=1 causes no retire and no change of state.
- FAULT: IMemReq=0, InstrValid=0, Misaligned=1, CurrentPC holds the faulting value. The only exit is Reset.

Timing:
- Minimum retire-to-retire time is 2 cycles: FETCH with zero-wait memory, then HOLD with Advance.
- Fetch latency is 1 + N cycles, where N is the number of cycles IMemReady stays low.

Arithmetic and boundaries:
- PC arithmetic is done entirely by the next-PC logic; this block never increments the PC itself. A NextPC of all ones minus 3 followed by 0 is legal; wrap-around is not checked.
- RetireCount wraps modulo 2^CNT_WIDTH, with no saturation.
- IMemReady asserted outside FETCH is ignored, and IMemData is not captured.
- Reset asserted in the same cycle as IMemReady: Reset wins and the data is discarded.

Test Plan:
1. Reset sequence and straight-line fetch:
   - Stimulus: Reset for 2 cycles with RESET_PC=0, then zero-wait memory (IMemReady=1) returning 32'hAAAA0001, NextPC=4, Advance pulsed.
   - Required response: IMemAddr=0, then 4. InstrValid is high 1 cycle after the request. RetireCount=1 after the pulse.
2. Wait states:
   - Stimulus: IMemReady held low for 3 cycles while in FETCH at PC=4.
   - Required response: IMemReq=1 and IMemAddr=4 stable for 4 cycles. InstrValid rises the cycle after IMemReady=1. Instruction equals the data sampled on that cycle.
3. Branch taken:
   - Stimulus: at CurrentPC=0, drive NextPC=8 (SignExtImm64=2 shifted) and retire.
   - Required response: next IMemAddr=8, CurrentPC=8, no Misaligned.
4. Stall:
   - Stimulus: in HOLD, Advance=1 with Stall=1 for 3 cycles, then Stall=0.
   - Required response: CurrentPC and RetireCount unchanged during the stall. Exactly one retire occurs when Stall drops.
5. Misaligned fault:
   - Stimulus: retire with NextPC=6.
   - Required response: Misaligned=1 and CurrentPC=6 on the next cycle. IMemReq stays 0 despite further Advance pulses. Reset clears the fault and restores CurrentPC=0.
6. Reset mid-handshake:
   - Stimulus: in FETCH at PC=8, assert Reset in the same cycle as IMemReady=1 with IMemData=32'hDEADBEEF.
   - Required response: InstrValid=0, Instruction=0, CurrentPC=RESET_PC on the next cycle.
